// File: rtl/exu_trap_ctrl_pkg.sv
// Shared constants and types for the EXU trap-response controller.
// Optional mtval support is controlled by the EXU_TRAP_MTVAL_EN macro.
package exu_trap_ctrl_pkg;

    localparam int XLEN = 32;

    // Machine trap CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus fields that exist in this core; every other bit reads 0
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_1888;
    localparam logic [XLEN-1:0] MSTATUS_RST   = 32'h0000_1800;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    // Kind of request latched at the commit handshake
    typedef enum logic {
        REQ_TRAP = 1'b0,
        REQ_MRET = 1'b1
    } req_kind_e;

    // Clear the two low bits (word-aligned PC / vector base)
    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/exu_trap_ctrl_if.sv
// Commit-trap interface between the exception unit (master) and the
// trap controller (slave).
//
// Handshake: a request (cmt_trap_valid or cmt_mret_valid) is consumed at a
// rising clock edge where valid=1 and cmt_ready=1. While cmt_ready=0 the
// master must hold valid and the payload stable. cmt_ready is shared by both
// request kinds; if both are valid together the trap is taken and the mret
// is consumed and dropped.
interface exu_trap_ctrl_if;
    import exu_trap_ctrl_pkg::*;

    logic            cmt_trap_valid;
    logic            cmt_mret_valid;
    logic            cmt_ready;
    logic [XLEN-1:0] cmt_cause;
    logic [XLEN-1:0] cmt_pc;
    logic [XLEN-1:0] cmt_tval;

    modport master (
        output cmt_trap_valid, cmt_mret_valid, cmt_cause, cmt_pc, cmt_tval,
        input  cmt_ready
    );

    modport slave (
        input  cmt_trap_valid, cmt_mret_valid, cmt_cause, cmt_pc, cmt_tval,
        output cmt_ready
    );

endinterface

// File: rtl/exu_trap_csr_regs.sv
// Machine trap CSR storage, read mux and write priority.
// mtval exists only when EXU_TRAP_MTVAL_EN is defined.
module exu_trap_csr_regs
    import exu_trap_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_we,
    input  logic [11:0]     csr_idx,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            upd_trap,
    input  logic            upd_mret,
    input  logic [XLEN-1:0] upd_cause,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_tval,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] mret_target
);

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef EXU_TRAP_MTVAL_EN
    logic [XLEN-1:0] mtval_q, mtval_d;
`else
    logic unused_tval;
    assign unused_tval = ^upd_tval;
`endif

    // Only direct-mode vectoring: the target is always the aligned base
    assign trap_target = align4(mtvec_q);
    assign mret_target = mepc_q;

    // Next-state: software write first, trap/mret update overrides the registers it owns
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
`ifdef EXU_TRAP_MTVAL_EN
        mtval_d   = mtval_q;
`endif
        if (csr_we) begin
            case (csr_idx)
                CSR_MSTATUS: mstatus_d = csr_wdata & MSTATUS_WMASK;
                CSR_MTVEC:   mtvec_d   = align4(csr_wdata);
                CSR_MEPC:    mepc_d    = align4(csr_wdata);
                CSR_MCAUSE:  mcause_d  = csr_wdata;
`ifdef EXU_TRAP_MTVAL_EN
                CSR_MTVAL:   mtval_d   = csr_wdata;
`endif
                default: ;
            endcase
        end
        if (upd_trap) begin
            mepc_d   = align4(upd_pc);
            mcause_d = upd_cause;
            mstatus_d = '0;
            mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
`ifdef EXU_TRAP_MTVAL_EN
            mtval_d  = upd_tval;
`endif
        end else if (upd_mret) begin
            mstatus_d = mstatus_q;
            mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE] = 1'b1;
        end
    end

    // Combinational read from current register values, no bypass
    always_comb begin
        csr_rdata = '0;
        case (csr_idx)
            CSR_MSTATUS: csr_rdata = mstatus_q;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
`ifdef EXU_TRAP_MTVAL_EN
            CSR_MTVAL:   csr_rdata = mtval_q;
`endif
            default:     csr_rdata = '0;
        endcase
    end

    // CSR registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q <= MSTATUS_RST;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
`ifdef EXU_TRAP_MTVAL_EN
            mtval_q   <= '0;
`endif
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
`ifdef EXU_TRAP_MTVAL_EN
            mtval_q   <= mtval_d;
`endif
        end
    end

endmodule

// File: rtl/exu_trap_ctrl.sv
// EXU trap-response controller: accepts commit traps and mret, updates the
// machine trap CSRs and redirects the IFU via a flush_req/flush_ack handshake.
// Optional mtval register: EXU_TRAP_MTVAL_EN.
//
// Flush handshake: flush_req stays high with flush_pc stable until a rising
// edge with flush_ack=1; flush_ack outside FLUSH has no effect.
module exu_trap_ctrl
    import exu_trap_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    exu_trap_ctrl_if.slave       cmt,
    input  logic                 csr_ena,
    input  logic                 csr_wr_en,
    input  logic [11:0]          csr_idx,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 flush_req,
    output logic [XLEN-1:0]      flush_pc,
    input  logic                 flush_ack,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    logic [1:0]      state_q, state_d;
    req_kind_e       kind_q, kind_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] flush_pc_q, flush_pc_d;
    logic [XLEN-1:0] trap_target, mret_target;
    logic            upd_trap, upd_mret;

    assign cmt.cmt_ready = (state_q == ST_IDLE);
    assign flush_req     = (state_q == ST_FLUSH);
    assign flush_pc      = flush_pc_q;
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;
    assign upd_trap      = (state_q == ST_UPDATE) && (kind_q == REQ_TRAP);
    assign upd_mret      = (state_q == ST_UPDATE) && (kind_q == REQ_MRET);

    // FSM next state, request latching and redirect target capture
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        tval_d     = tval_q;
        flush_pc_d = flush_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (cmt.cmt_trap_valid || cmt.cmt_mret_valid) begin
                    state_d = ST_UPDATE;
                    // Trap wins; a simultaneous mret is dropped
                    kind_d  = cmt.cmt_trap_valid ? REQ_TRAP : REQ_MRET;
                    cause_d = cmt.cmt_cause;
                    pc_d    = cmt.cmt_pc;
                    tval_d  = cmt.cmt_tval;
                end
            end
            ST_UPDATE: begin
                flush_pc_d = (kind_q == REQ_TRAP) ? trap_target : mret_target;
                state_d    = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state with synchronous reset; reset abandons any pending flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            kind_q     <= REQ_TRAP;
            cause_q    <= '0;
            pc_q       <= '0;
            tval_q     <= '0;
            flush_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            tval_q     <= tval_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    exu_trap_csr_regs u_csr_regs (
        .clk         (clk),
        .rst         (rst),
        .csr_we      (csr_ena && csr_wr_en),
        .csr_idx     (csr_idx),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .upd_trap    (upd_trap),
        .upd_mret    (upd_mret),
        .upd_cause   (cause_q),
        .upd_pc      (pc_q),
        .upd_tval    (tval_q),
        .trap_target (trap_target),
        .mret_target (mret_target)
    );

endmodule

// File: tb/tb_exu_trap_ctrl.sv
// Self-checking bench for exu_trap_ctrl: directed scenarios plus randomized
// traffic against a field-level reference model of the trap CSRs.
module tb_exu_trap_ctrl;
    import exu_trap_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exu_trap_ctrl_if cmt_if ();

    logic        csr_ena, csr_wr_en;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdata, csr_rdata;
    logic        flush_req, flush_ack, busy;
    logic [31:0] flush_pc;
    logic [1:0]  dbg_state;

    exu_trap_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmt       (cmt_if),
        .csr_ena   (csr_ena),
        .csr_wr_en (csr_wr_en),
        .csr_idx   (csr_idx),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .flush_req (flush_req),
        .flush_pc  (flush_pc),
        .flush_ack (flush_ack),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    bit ack_hold  = 1'b0;
    bit ack_force = 1'b0;

    // ---------------- reference model ----------------
    bit          m_mie, m_mpie;
    logic [1:0]  m_mpp;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0; m_mpp = 2'd3;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] idx);
        case (idx)
            12'h300: return (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef EXU_TRAP_MTVAL_EN
            12'h343: return m_mtval;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [11:0] idx, input logic [31:0] d);
        case (idx)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; m_mpp = d[12:11]; end
            12'h305: m_mtvec  = d & 32'hFFFF_FFFC;
            12'h341: m_mepc   = d & 32'hFFFF_FFFC;
            12'h342: m_mcause = d;
`ifdef EXU_TRAP_MTVAL_EN
            12'h343: m_mtval  = d;
`endif
            default: ;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_read_check(input logic [11:0] idx, input string name);
        @(negedge clk);
        csr_idx = idx;
        #1 check(name, csr_rdata, model_read(idx));
    endtask

    task automatic check_all_csrs(input string tag);
        csr_read_check(12'h300, {tag, "_mstatus"});
        csr_read_check(12'h305, {tag, "_mtvec"});
        csr_read_check(12'h341, {tag, "_mepc"});
        csr_read_check(12'h342, {tag, "_mcause"});
        csr_read_check(12'h343, {tag, "_mtval"});
        csr_read_check(12'h7C0, {tag, "_unmapped"});
    endtask

    task automatic csr_write(input logic [11:0] idx, input logic [31:0] d);
        @(negedge clk);
        csr_ena = 1; csr_wr_en = 1; csr_idx = idx; csr_wdata = d;
        model_write(idx, d);
        @(negedge clk);
        csr_ena = 0; csr_wr_en = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) check("idle_timeout", 32'(busy), 32'h0);
    endtask

    // Issue a commit request; optionally write a CSR during the UPDATE cycle
    task automatic send(input bit t, input bit m, input logic [31:0] cause,
                        input logic [31:0] pc, input logic [31:0] tval,
                        input bit upd_wr, input logic [11:0] wr_idx, input logic [31:0] wr_data);
        int waited = 0;
        logic [31:0] tgt;
        bit owned;
        @(negedge clk);
        cmt_if.cmt_trap_valid = t; cmt_if.cmt_mret_valid = m;
        cmt_if.cmt_cause = cause; cmt_if.cmt_pc = pc; cmt_if.cmt_tval = tval;
        while (!cmt_if.cmt_ready && waited < 100) begin @(negedge clk); waited++; end
        if (!cmt_if.cmt_ready) begin
            check("accept_timeout", 32'(cmt_if.cmt_ready), 32'h1);
            cmt_if.cmt_trap_valid = 0; cmt_if.cmt_mret_valid = 0;
            return;
        end
        if (t) begin
            tgt = m_mtvec & 32'hFFFF_FFFC;
            m_mepc = pc & 32'hFFFF_FFFC; m_mcause = cause;
            m_mpie = m_mie; m_mie = 0; m_mpp = 2'd3; m_mtval = tval;
        end else begin
            tgt = m_mepc;
            m_mie = m_mpie; m_mpie = 1;
        end
        exp_q.push_back(tgt);
        @(posedge clk);
        #1 check("lat_no_flush_in_update", 32'(flush_req), 32'h0);
        @(negedge clk);
        cmt_if.cmt_trap_valid = 0; cmt_if.cmt_mret_valid = 0;
        if (upd_wr) begin
            csr_ena = 1; csr_wr_en = 1; csr_idx = wr_idx; csr_wdata = wr_data;
            owned = (wr_idx == 12'h300);
`ifdef EXU_TRAP_MTVAL_EN
            if (t && (wr_idx == 12'h341 || wr_idx == 12'h342 || wr_idx == 12'h343)) owned = 1;
`else
            if (t && (wr_idx == 12'h341 || wr_idx == 12'h342)) owned = 1;
`endif
            if (!owned) model_write(wr_idx, wr_data);
        end
        @(posedge clk);
        #1 check("lat_flush_req_rise", 32'(flush_req), 32'h1);
        @(negedge clk);
        csr_ena = 0; csr_wr_en = 0;
    endtask

    // ---------------- IFU ack driver ----------------
    initial begin
        flush_ack = 0;
        forever begin
            @(negedge clk);
            #1;
            if (ack_force)     flush_ack = 1;
            else if (ack_hold) flush_ack = 0;
            else               flush_ack = ($urandom_range(0, 2) == 0);
        end
    end

    // ---------------- monitor: pops expected redirect targets ----------------
    initial begin
        bit active = 0;
        bit prev_req = 0;
        logic [31:0] cur = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) active = 0;
            else if (active && prev_req && flush_ack) active = 0;
            if (flush_req && !rst) begin
                if (!active) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_flush", flush_pc, 32'hFFFF_FFFF);
                        cur = flush_pc;
                    end else begin
                        cur = exp_q.pop_front();
                        check("flush_pc", flush_pc, cur);
                    end
                    active = 1;
                end else begin
                    check("flush_pc_stable", flush_pc, cur);
                end
            end
            prev_req = flush_req;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    logic [11:0] idx_list[6];

    initial begin
        logic [11:0] widx;
        int kind;
        idx_list = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h7C0};
        rst = 1;
        cmt_if.cmt_trap_valid = 0; cmt_if.cmt_mret_valid = 0;
        cmt_if.cmt_cause = 0; cmt_if.cmt_pc = 0; cmt_if.cmt_tval = 0;
        csr_ena = 0; csr_wr_en = 0; csr_idx = 0; csr_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;

        // Reset state
        #1;
        check("rst_flush_req", 32'(flush_req), 32'h0);
        check("rst_cmt_ready", 32'(cmt_if.cmt_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_flush_pc", flush_pc, 32'h0);
        csr_read_check(12'h300, "rst_mstatus_const");
        check("rst_mstatus_1800", csr_rdata, 32'h0000_1800);
        check_all_csrs("rst");

        // Directed trap with held ack
        csr_write(12'h305, 32'h8000_0103);
        csr_write(12'h300, 32'h0000_0008);
        check_all_csrs("setup");
        ack_hold = 1;
        send(1, 0, 32'd3, 32'h8000_0012, 32'hDEAD_BEEF, 0, 12'h0, 32'h0);
        @(negedge clk);
        cmt_if.cmt_trap_valid = 1; cmt_if.cmt_cause = 32'd5; cmt_if.cmt_pc = 32'h4444_4444;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("hold_cmt_ready", 32'(cmt_if.cmt_ready), 32'h0);
            check("hold_flush_req", 32'(flush_req), 32'h1);
            check("hold_flush_pc", flush_pc, 32'h8000_0100);
        end
        csr_read_check(12'h341, "trap_mepc");
        check("trap_mepc_const", csr_rdata, 32'h8000_0010);
        csr_read_check(12'h342, "trap_mcause");
        csr_read_check(12'h300, "trap_mstatus");
        check("trap_mstatus_const", csr_rdata, 32'h0000_1880);
        csr_read_check(12'h343, "trap_mtval");
        @(negedge clk);
        cmt_if.cmt_trap_valid = 0;
        ack_hold = 0; ack_force = 1;
        @(posedge clk);
        #1;
        check("ack_idle_busy", 32'(busy), 32'h0);
        check("ack_idle_ready", 32'(cmt_if.cmt_ready), 32'h1);
        ack_force = 0;
        csr_read_check(12'h342, "no_accept_while_flush");

        // mret after the trap
        send(0, 1, 32'h0, 32'h0, 32'h0, 0, 12'h0, 32'h0);
        wait_idle();
        csr_read_check(12'h300, "mret_mstatus");
        check("mret_mstatus_const", csr_rdata, 32'h0000_1888);

        // Simultaneous trap+mret, conflicting mepc write in UPDATE
        send(1, 1, 32'd7, 32'h0000_2226, 32'h1111_2222, 1, 12'h341, 32'h1234_5678);
        wait_idle();
        csr_read_check(12'h341, "prio_mepc");
        check("prio_mepc_const", csr_rdata, 32'h0000_2224);
        csr_read_check(12'h342, "prio_mcause");

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            widx = idx_list[$urandom_range(0, 5)];
            if (kind == 0) begin
                csr_write(widx, $urandom);
            end else begin
                send(kind != 2, kind != 1, $urandom, $urandom, $urandom,
                     ($urandom_range(0, 2) == 0), widx, $urandom);
                wait_idle();
            end
            check_all_csrs("rand");
        end

        // Reset while in FLUSH
        ack_hold = 1;
        send(1, 0, 32'd11, 32'h0000_0400, 32'hCAFE_F00D, 0, 12'h0, 32'h0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        check("rstflush_flush_req", 32'(flush_req), 32'h0);
        check("rstflush_busy", 32'(busy), 32'h0);
        check("rstflush_flush_pc", flush_pc, 32'h0);
        @(negedge clk);
        rst = 0;
        ack_hold = 0;
        model_reset();
        check_all_csrs("rstflush");

        wait_idle();
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
